// File: rtl/rsa_operand_loader_if.sv
// rsa_operand_loader_if
//   Word stream feeding rsa_operand_loader.
//   in_valid : word valid (master -> slave)
//   in_ready : slave can accept a word (slave -> master)
//   in_data  : operand word, least-significant word first
//   in_sel   : target operand, 0 = c, 1 = e, 2 = n, 3 = reserved
interface rsa_operand_loader_if #(
  parameter int WORD = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [WORD-1:0] in_data;
  logic [1:0]      in_sel;

  modport master (output in_valid, output in_data, output in_sel, input in_ready);
  modport slave  (input in_valid, input in_data, input in_sel, output in_ready);
endinterface

// File: rtl/rsa_operand_loader.sv
// rsa_operand_loader
//   Assembles the 2048-bit operands c, e and n for RSA_TOP from a 32-bit
//   word stream, then raises enable and holds it until RSA_TOP reports
//   finish. After finish drops the loader re-arms for the next operation.
//
//   Ports:
//     clk      : single clock, rising edge
//     sys_rst  : asynchronous active-high reset
//     s_in     : word stream (rsa_operand_loader_if.slave)
//     c, e, n  : assembled operands
//     enable   : start/hold request to RSA_TOP (registered)
//     finish   : completion flag from RSA_TOP
//     busy     : high while running or draining (registered)
//     err      : sticky flags, [0] overflow, [1] reserved select (registered)
//
//   Build option: define LOADER_KEY_RETAIN_EN to keep e and n loaded across
//   runs, so that later runs only need a fresh c.
module rsa_operand_loader #(
  parameter int WIDTH = 2048,
  parameter int WORD  = 32
) (
  input  logic                 clk,
  input  logic                 sys_rst,
  rsa_operand_loader_if.slave  s_in,
  output logic [WIDTH-1:0]     c,
  output logic [WIDTH-1:0]     e,
  output logic [WIDTH-1:0]     n,
  output logic                 enable,
  input  logic                 finish,
  output logic                 busy,
  output logic [1:0]           err
);

  localparam int NWORDS = WIDTH / WORD;
  localparam int CW     = $clog2(NWORDS + 1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [CW-1:0]   cnt_r [0:2];
  logic [2:0]      loaded_r;
  logic [2:0]      loaded_nxt_s;
  logic [2:0]      sel_oh_s;
  logic [2:0]      wr_s;
  logic            accept_s;
  logic            ovf_s;
  logic            rsv_s;
  logic            clear_s;
  logic            enable_r;
  logic            busy_r;
  logic [1:0]      err_r;

  assign s_in.in_ready = (state_r == ST_LOAD);
  assign accept_s      = s_in.in_valid && (state_r == ST_LOAD);
  assign enable        = enable_r;
  assign busy          = busy_r;
  assign err           = err_r;

  // Decode the select into a one-hot operand strobe; 3 selects nothing.
  always_comb begin
    sel_oh_s = 3'b000;
    case (s_in.in_sel)
      2'd0:    sel_oh_s = 3'b001;
      2'd1:    sel_oh_s = 3'b010;
      2'd2:    sel_oh_s = 3'b100;
      default: sel_oh_s = 3'b000;
    endcase
  end

  // Per-word bookkeeping: which register shifts, which flag becomes set,
  // and whether the word is discarded as overflow or reserved.
  always_comb begin
    wr_s         = 3'b000;
    ovf_s        = 1'b0;
    rsv_s        = accept_s && (s_in.in_sel == 2'd3);
    loaded_nxt_s = loaded_r;
    for (int i = 0; i < 3; i++) begin
      if (accept_s && sel_oh_s[i]) begin
        if (loaded_r[i]) begin
          ovf_s = 1'b1;
        end else begin
          wr_s[i] = 1'b1;
          loaded_nxt_s[i] = (cnt_r[i] == CW'(NWORDS - 1));
        end
      end else begin
        wr_s[i] = 1'b0;
      end
    end
  end

  // Next-state logic; LOAD launches on the edge where all flags are or become set.
  always_comb begin
    state_nxt_s = state_r;
    clear_s     = 1'b0;
    case (state_r)
      ST_LOAD: begin
        if (&loaded_nxt_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (finish) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!finish) begin
          state_nxt_s = ST_LOAD;
          clear_s     = 1'b1;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_LOAD;
      end
    endcase
  end

  // State register plus registered enable/busy derived from the next state.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r  <= ST_LOAD;
      enable_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      enable_r <= (state_nxt_s == ST_RUN);
      busy_r   <= (state_nxt_s != ST_LOAD);
    end
  end

  // Word counters and loaded flags; cleared when DRAIN hands back to LOAD.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < 3; i++) begin
        cnt_r[i] <= '0;
      end
      loaded_r <= 3'b000;
    end else if (clear_s) begin
`ifdef LOADER_KEY_RETAIN_EN
      // Key (e, n) stays resident; only the message operand re-arms.
      cnt_r[0] <= '0;
      loaded_r <= {loaded_r[2:1], 1'b0};
`else
      for (int i = 0; i < 3; i++) begin
        cnt_r[i] <= '0;
      end
      loaded_r <= 3'b000;
`endif
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (wr_s[i]) begin
          cnt_r[i] <= cnt_r[i] + CW'(1);
        end
      end
      loaded_r <= loaded_nxt_s;
    end
  end

  // Operand shift registers: new word enters at the top, so the first word
  // ends up in the least-significant position after NWORDS words.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      c <= '0;
      e <= '0;
      n <= '0;
    end else begin
      if (wr_s[0]) c <= {s_in.in_data, c[WIDTH-1:WORD]};
      if (wr_s[1]) e <= {s_in.in_data, e[WIDTH-1:WORD]};
      if (wr_s[2]) n <= {s_in.in_data, n[WIDTH-1:WORD]};
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      err_r <= 2'b00;
    end else begin
      err_r <= err_r | {rsv_s, ovf_s};
    end
  end

endmodule

// File: tb/tb_rsa_operand_loader.sv
// tb_rsa_operand_loader
//   Directed bench for rsa_operand_loader at default parameters. Expected
//   operand images are built directly from the word values (word i lands at
//   bits [32*i +: 32]). Covers the LOADER_KEY_RETAIN_EN build under ifdef.
module tb_rsa_operand_loader;

  localparam int WIDTH = 2048;
  localparam int WORD  = 32;
  localparam int NW    = WIDTH / WORD;

  logic             clk;
  logic             sys_rst;
  logic [WIDTH-1:0] c, e, n;
  logic             enable;
  logic             finish;
  logic             busy;
  logic [1:0]       err;

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] exp_c1, exp_e1, exp_n1, exp_c2, exp_e2, exp_n2;

  rsa_operand_loader_if #(.WORD(WORD)) bus ();

  rsa_operand_loader #(.WIDTH(WIDTH), .WORD(WORD)) dut (
    .clk     (clk),
    .sys_rst (sys_rst),
    .s_in    (bus.slave),
    .c       (c),
    .e       (e),
    .n       (n),
    .enable  (enable),
    .finish  (finish),
    .busy    (busy),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare and report; wide values print the first differing 32-bit word.
  task automatic check_val(input string tag, input logic [WIDTH-1:0] act,
                           input logic [WIDTH-1:0] exp);
    int idx;
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      idx = 0;
      for (int k = NW - 1; k >= 0; k--) begin
        if (act[k*WORD +: WORD] !== exp[k*WORD +: WORD]) idx = k;
      end
      $display("FAIL %s: word %0d got %h expected %h", tag, idx,
               act[idx*WORD +: WORD], exp[idx*WORD +: WORD]);
    end
  endtask

  function automatic logic [WIDTH-1:0] build(input logic [31:0] base);
    logic [WIDTH-1:0] v;
    for (int k = 0; k < NW; k++) v[k*WORD +: WORD] = base + 32'(k);
    return v;
  endfunction

  // One word, presented half a cycle before the edge; sampled 1 time unit after.
  task automatic send_word(input logic [1:0] sel, input logic [31:0] data);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_data  = data;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // RSA_TOP model: finish high 100 cycles after launch, held for 3 cycles.
  task automatic finish_handshake(input logic [WIDTH-1:0] ec, input logic [WIDTH-1:0] ee,
                                  input logic [WIDTH-1:0] en);
    // A word held valid while in_ready is low must not be taken.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sel   = 2'd0;
    bus.in_data  = 32'hAAAA_5555;
    repeat (5) @(posedge clk);
    #1;
    check_val("run_c_stable", c, ec);
    check_val("run_ready_low", {2047'd0, bus.in_ready}, {2047'd0, 1'b0});
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (93) @(negedge clk);
    check_val("run_enable_hold", {2047'd0, enable}, {2047'd0, 1'b1});
    finish = 1'b1;
    @(posedge clk);
    #1;
    check_val("fin_enable_low", {2047'd0, enable}, {2047'd0, 1'b0});
    check_val("fin_busy_drain", {2047'd0, busy}, {2047'd0, 1'b1});
    repeat (2) @(posedge clk);
    @(negedge clk);
    finish = 1'b0;
    check_val("drain_ready_low", {2047'd0, bus.in_ready}, {2047'd0, 1'b0});
    @(posedge clk);
    #1;
    check_val("rearm_ready", {2047'd0, bus.in_ready}, {2047'd0, 1'b1});
    check_val("rearm_busy", {2047'd0, busy}, {2047'd0, 1'b0});
    check_val("rearm_e_kept", e, ee);
    check_val("rearm_n_kept", n, en);
    // finish has no effect in LOAD.
    @(negedge clk);
    finish = 1'b1;
    @(posedge clk);
    #1;
    check_val("load_ignores_finish", {2046'd0, busy, bus.in_ready}, {2046'd0, 1'b0, 1'b1});
    @(negedge clk);
    finish = 1'b0;
  endtask

  initial begin
    exp_c1 = build(32'h0000_0000);
    exp_e1 = build(32'h0000_1000);
    exp_n1 = build(32'h0000_2000);
    exp_c2 = build(32'h0000_3000);
    exp_e2 = build(32'h0000_4000);
    exp_n2 = build(32'h0000_5000);

    sys_rst      = 1'b1;
    finish       = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sel   = 2'd0;
    bus.in_data  = 32'h0;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    sys_rst = 1'b0;
    #1;
    check_val("rst_c", c, '0);
    check_val("rst_e", e, '0);
    check_val("rst_n", n, '0);
    check_val("rst_flags", {2043'd0, enable, busy, err, bus.in_ready},
              {2043'd0, 1'b0, 1'b0, 2'b00, 1'b1});

    // Interleaved load of the first operand set
    for (int i = 0; i < NW; i++) begin
      send_word(2'd0, 32'(i));
      send_word(2'd1, 32'h1000 + 32'(i));
      if (i == NW - 1) begin
        check_val("pre_launch_enable", {2047'd0, enable}, {2047'd0, 1'b0});
        check_val("pre_launch_ready", {2047'd0, bus.in_ready}, {2047'd0, 1'b1});
      end
      send_word(2'd2, 32'h2000 + 32'(i));
    end
    check_val("launch_enable", {2047'd0, enable}, {2047'd0, 1'b1});
    check_val("launch_ready", {2047'd0, bus.in_ready}, {2047'd0, 1'b0});
    check_val("launch_busy", {2047'd0, busy}, {2047'd0, 1'b1});
    check_val("c_low_word", {2016'd0, c[31:0]}, {2016'd0, 32'd0});
    check_val("c_top_word", {2016'd0, c[2047:2016]}, {2016'd0, 32'd63});
    check_val("n_word1", {2016'd0, n[63:32]}, {2016'd0, 32'h2001});
    check_val("c_full", c, exp_c1);
    check_val("e_full", e, exp_e1);
    check_val("n_full", n, exp_n1);

    finish_handshake(exp_c1, exp_e1, exp_n1);

`ifdef LOADER_KEY_RETAIN_EN
    // Only c is needed for the second run
    for (int i = 0; i < NW; i++) begin
      if (i == NW - 1) check_val("keep_pre_enable", {2047'd0, enable}, {2047'd0, 1'b0});
      send_word(2'd0, 32'h3000 + 32'(i));
    end
    check_val("keep_launch", {2047'd0, enable}, {2047'd0, 1'b1});
    check_val("keep_c", c, exp_c2);
    check_val("keep_e", e, exp_e1);
    check_val("keep_n", n, exp_n1);
    finish_handshake(exp_c2, exp_e1, exp_n1);
    send_word(2'd1, 32'hDEAD_BEEF);
    check_val("key_ovf_err", {2046'd0, err}, {2046'd0, 2'b01});
    check_val("key_ovf_e", e, exp_e1);
    send_word(2'd3, 32'h1234_5678);
    check_val("rsv_err", {2046'd0, err}, {2046'd0, 2'b11});
    check_val("rsv_n", n, exp_n1);
    for (int i = 0; i < NW; i++) send_word(2'd0, 32'h3000 + 32'(i));
    check_val("relaunch", {2047'd0, enable}, {2047'd0, 1'b1});
`else
    // Second set: c alone must not launch; exercise both error flags
    for (int i = 0; i < NW; i++) send_word(2'd0, 32'h3000 + 32'(i));
    check_val("c_only_no_launch", {2046'd0, enable, busy}, {2046'd0, 1'b0, 1'b0});
    check_val("no_err_yet", {2046'd0, err}, {2046'd0, 2'b00});
    send_word(2'd0, 32'hDEAD_BEEF);
    check_val("ovf_err", {2046'd0, err}, {2046'd0, 2'b01});
    check_val("ovf_c_unchanged", c, exp_c2);
    send_word(2'd3, 32'h1234_5678);
    check_val("rsv_err", {2046'd0, err}, {2046'd0, 2'b11});
    check_val("rsv_c", c, exp_c2);
    check_val("rsv_e", e, exp_e1);
    check_val("rsv_n", n, exp_n1);
    for (int i = 0; i < NW; i++) begin
      send_word(2'd1, 32'h4000 + 32'(i));
      if (i == NW - 1) check_val("second_pre_enable", {2047'd0, enable}, {2047'd0, 1'b0});
      send_word(2'd2, 32'h5000 + 32'(i));
    end
    check_val("second_launch", {2047'd0, enable}, {2047'd0, 1'b1});
    check_val("second_c", c, exp_c2);
    check_val("second_e", e, exp_e2);
    check_val("second_n", n, exp_n2);
    check_val("err_sticky", {2046'd0, err}, {2046'd0, 2'b11});
`endif

    // Reset 10 cycles into RUN: enable must drop without a clock edge
    repeat (10) @(posedge clk);
    @(negedge clk);
    sys_rst = 1'b1;
    #1;
    check_val("midrst_enable", {2047'd0, enable}, {2047'd0, 1'b0});
    check_val("midrst_flags", {2044'd0, busy, err, bus.in_ready},
              {2044'd0, 1'b0, 2'b00, 1'b1});
    check_val("midrst_c", c, '0);
    check_val("midrst_e", e, '0);
    check_val("midrst_n", n, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    sys_rst = 1'b0;
    @(posedge clk);
    #1;
    check_val("post_rst_state", {2045'd0, enable, busy, bus.in_ready},
              {2045'd0, 1'b0, 1'b0, 1'b1});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rsa_operand_loader.md
# rsa_operand_loader

Upstream feeder for `RSA_TOP`. It accepts 32-bit words over a valid/ready stream and assembles them into the 2048-bit operands `c`, `e` and `n`. Once all three operands are complete it raises `enable` and holds it until the exponentiator reports `finish`. It then waits for `finish` to drop before re-arming for the next operation.

## Interface
Parameters:
- `WIDTH`, 2048: operand width; must be a multiple of `WORD`.
- `WORD`, 32: input word width. `NWORDS = WIDTH/WORD` (64 at defaults).

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `sys_rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: input word valid.
- `in_ready` out 1: loader can accept a word.
- `in_data` in WORD: operand word, least-significant word first.
- `in_sel` in 2: target operand. 0 = c, 1 = e, 2 = n, 3 = reserved.
- `c`, `e`, `n` out WIDTH: assembled operands, wired to `RSA_TOP`.
- `enable` out 1: start/hold request to `RSA_TOP`.
- `finish` in 1: completion flag from `RSA_TOP`.
- `busy` out 1: high in the RUN and DRAIN states.
- `err` out 2: sticky error flags. Bit 0 = overflow (word sent to an operand that is already full). Bit 1 = reserved `in_sel`.

## Operation
- **Transfer:** a word transfers on a rising edge with `in_valid && in_ready`. `in_ready = (state == LOAD)`.
- **Per-operand state:** each operand has a word counter (0..`NWORDS`) and a `loaded` flag.
- **Assembly:** on an accepted word, the selected register shifts right by `WORD` and `in_data` enters at bits `[WIDTH-1 -: WORD]`. After `NWORDS` words, the first word sits at `[WORD-1:0]`.
- **Loaded flag:** when the counter reaches `NWORDS`, the operand's `loaded` flag is set.
- **Interleaving:** words for different operands may be interleaved in any order.
- **Overflow:** a word for an operand whose `loaded` flag is set is consumed but discarded. The register is unchanged and `err[0]` is set.
- **Reserved select:** `in_sel == 3` consumes and discards the word and sets `err[1]`.
- **`err` clearing:** both bits clear only on reset.

State machine:
- **LOAD:**
  - Accepts words.
  - Moves to RUN on the same edge where all three `loaded` flags are, or become, set. This includes the edge that accepts the final word.
- **RUN:**
  - `enable = 1`, `in_ready = 0`.
  - When `finish == 1` is sampled, moves to DRAIN and `enable` clears on that edge.
- **DRAIN:**
  - `enable = 0`.
  - When `finish == 0` is sampled, moves to LOAD.
  - On that edge, all counters and `loaded` flags clear. Operand register contents are retained but will be overwritten by the next load.
- `finish` is ignored in LOAD.

Reset (asynchronous, immediate):
- State goes to LOAD.
- `c`, `e`, `n`, counters, `loaded` flags and `err` go to 0.
- `enable = 0`, `busy = 0`, `in_ready = 1`. No transfer occurs while `sys_rst` is high.
- Reset asserted during RUN drops `enable` without waiting for an edge.

## Timing
- `enable`, `busy` and `err` are registered outputs.
- Minimum time to launch is `3*NWORDS` accepted words. `enable` rises on the edge that accepts the last word.
- `finish`→`enable` low: 1 edge.
- `finish` low→`in_ready` high: 1 edge after DRAIN samples `finish == 0`.
- `in_valid` may be held high with `in_ready` low; the word is accepted on the next LOAD edge.
- Operands are stable for the whole time `enable` is high.

## Configuration
- **`LOADER_KEY_RETAIN_EN` defined:**
  - On DRAIN→LOAD, only the counter and `loaded` flag for `c` are cleared. The flags for `e` and `n` stay set.
  - The next run therefore launches after `NWORDS` `c` words.
  - Words sent to `e` or `n` after the first load count as overflow (`err[0]`). Reset is the only way to replace the key.
- **Undefined:** all three operands must be reloaded for every run.

## Test plan
1. **Reset:** assert `sys_rst` for 2 cycles → `c`, `e`, `n` = 0; `enable` = 0; `busy` = 0; `err` = 0; `in_ready` = 1.
2. **Load and launch:** load c words i = 0..63 with value i, e words 0x1000+i and n words 0x2000+i, interleaved c/e/n → `c[31:0]` = 0, `c[2047:2016]` = 63, `n[63:32]` = 0x2001. `enable` rises on the edge accepting the 192nd word and `in_ready` drops on that edge.
3. **Completion handshake:** model `finish` high 100 cycles after `enable`, held for 3 cycles → `enable` low 1 edge after `finish` is sampled high. `in_ready` = 1 one edge after `finish` falls. Then load a fresh set and check a second launch.
4. **Errors:** send a 65th word to `c` with value 0xDEADBEEF → `err` = 2'b01 and `c` unchanged. Then send `in_sel = 3` → `err` = 2'b11 and no operand changes.
5. **Reset mid-run:** assert `sys_rst` 10 cycles into RUN → `enable` goes to 0 asynchronously, state returns to LOAD and all operands read 0.
6. **`LOADER_KEY_RETAIN_EN` build:** after one full run, load only 64 `c` words → `enable` rises on the 64th word, with `e` and `n` unchanged from the first run.
